// File: rtl/pxs_sync_gen_pkg.sv
// Shared definitions for the Pxs pixel-stream stages: default 640x480@60
// timing, stream layout and background pattern selection.
package pxs_sync_gen_pkg;

    localparam int STREAM_W = 26;
    localparam int CNT_W    = 10;
    localparam int RGB_W    = 3;

    localparam int DEF_HVIS = 640;
    localparam int DEF_HFP  = 16;
    localparam int DEF_HSW  = 96;
    localparam int DEF_HBP  = 48;
    localparam int DEF_VVIS = 480;
    localparam int DEF_VFP  = 10;
    localparam int DEF_VSW  = 2;
    localparam int DEF_VBP  = 33;

    typedef enum logic [1:0] {
        PAT_BLACK   = 2'd0,
        PAT_BARS    = 2'd1,
        PAT_CHECKER = 2'd2
    } pattern_e;

    // Stream layout: [25] hsync, [24] vsync, [23] blank, [22:13] XC, [12:3] YC, [2:0] RGB
    function automatic logic [STREAM_W-1:0] packStream(
        input logic             hs,
        input logic             vs,
        input logic             blank,
        input logic [CNT_W-1:0] xc,
        input logic [CNT_W-1:0] yc,
        input logic [RGB_W-1:0] rgb
    );
        return {hs, vs, blank, xc, yc, rgb};
    endfunction

endpackage

// File: rtl/pxs_pattern_gen.sv
// Background pattern source for the sync generator: black, eight colour
// bars or a 32-pixel checkerboard, forced to black outside the visible area.
module pxs_pattern_gen
    import pxs_sync_gen_pkg::*;
#(
    parameter int HVIS    = DEF_HVIS,
    parameter int PATTERN = 0
) (
    input  logic             px_clk,
    input  logic             rst,
    input  logic             i_ce,
    input  logic             i_lineEnd,
    input  logic [CNT_W-1:0] i_hCnt,
    input  logic [CNT_W-1:0] i_vCnt,
    input  logic             i_blank,
    output logic [RGB_W-1:0] o_rgb
);

    localparam pattern_e   PAT      = pattern_e'(PATTERN[1:0]);
    localparam logic [6:0] BAR_LAST = 7'(HVIS / 8 - 1);

    logic [6:0]       r_barPix;
    logic [RGB_W-1:0] r_barIdx;
    logic             w_checker;
    logic             w_unused;

    assign w_checker = i_hCnt[5] ^ i_vCnt[5];
    assign w_unused  = ^{i_hCnt, i_vCnt};

    // Bar position tracks the horizontal counter so no divider is needed;
    // it restarts together with the line.
    always_ff @(posedge px_clk) begin
        if (rst) begin
            r_barPix <= 7'd0;
            r_barIdx <= '0;
        end else if (i_ce) begin
            if (i_lineEnd) begin
                r_barPix <= 7'd0;
                r_barIdx <= '0;
            end else if (r_barPix == BAR_LAST) begin
                r_barPix <= 7'd0;
                r_barIdx <= r_barIdx + 3'd1;
            end else begin
                r_barPix <= r_barPix + 7'd1;
            end
        end
    end

    always_comb begin
        o_rgb = 3'b000;
        if (!i_blank) begin
            case (PAT)
                PAT_BARS:    o_rgb = r_barIdx;
                PAT_CHECKER: o_rgb = {3{w_checker}};
                default:     o_rgb = 3'b000;
            endcase
        end
    end

endmodule

// File: rtl/pxs_sync_gen.sv
// Head-of-chain VGA timing generator: raster counters, registered pixel
// stream, frame-end strobe and completed-frame counter.
module pxs_sync_gen
    import pxs_sync_gen_pkg::*;
#(
    parameter int   HVIS    = DEF_HVIS,
    parameter int   HFP     = DEF_HFP,
    parameter int   HSW     = DEF_HSW,
    parameter int   HBP     = DEF_HBP,
    parameter int   VVIS    = DEF_VVIS,
    parameter int   VFP     = DEF_VFP,
    parameter int   VSW     = DEF_VSW,
    parameter int   VBP     = DEF_VBP,
    parameter logic HS_POL  = 1'b0,
    parameter logic VS_POL  = 1'b0,
    parameter int   PATTERN = 0
) (
    input  logic                px_clk,
    input  logic                rst,
    input  logic                ce,
    output logic [STREAM_W-1:0] RGBStr_o,
    output logic                frame_end_o,
    output logic [15:0]         frame_cnt_o
);

    localparam int HTOT = HVIS + HFP + HSW + HBP;
    localparam int VTOT = VVIS + VFP + VSW + VBP;

    localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(HTOT - 1);
    localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(VTOT - 1);
    localparam logic [CNT_W-1:0] H_VIS      = CNT_W'(HVIS);
    localparam logic [CNT_W-1:0] V_VIS      = CNT_W'(VVIS);
    localparam logic [CNT_W-1:0] H_VIS_LAST = CNT_W'(HVIS - 1);
    localparam logic [CNT_W-1:0] V_VIS_LAST = CNT_W'(VVIS - 1);
    localparam logic [CNT_W-1:0] H_SYNC_ON  = CNT_W'(HVIS + HFP);
    localparam logic [CNT_W-1:0] H_SYNC_OFF = CNT_W'(HVIS + HFP + HSW);
    localparam logic [CNT_W-1:0] V_SYNC_ON  = CNT_W'(VVIS + VFP);
    localparam logic [CNT_W-1:0] V_SYNC_OFF = CNT_W'(VVIS + VFP + VSW);

    logic [CNT_W-1:0] r_hCnt;
    logic [CNT_W-1:0] r_vCnt;
    logic             r_wrapPend;

    logic             w_hLast;
    logic             w_vLast;
    logic             w_blank;
    logic             w_hSync;
    logic             w_vSync;
    logic             w_frameEnd;
    logic [RGB_W-1:0] w_rgb;

    assign w_hLast    = (r_hCnt == H_LAST);
    assign w_vLast    = (r_vCnt == V_LAST);
    assign w_blank    = (r_hCnt >= H_VIS) || (r_vCnt >= V_VIS);
    assign w_hSync    = ((r_hCnt >= H_SYNC_ON) && (r_hCnt < H_SYNC_OFF)) ? HS_POL : ~HS_POL;
    assign w_vSync    = ((r_vCnt >= V_SYNC_ON) && (r_vCnt < V_SYNC_OFF)) ? VS_POL : ~VS_POL;
    assign w_frameEnd = (r_hCnt == H_VIS_LAST) && (r_vCnt == V_VIS_LAST);

    pxs_pattern_gen #(
        .HVIS    (HVIS),
        .PATTERN (PATTERN)
    ) u_pattern (
        .px_clk    (px_clk),
        .rst       (rst),
        .i_ce      (ce),
        .i_lineEnd (w_hLast),
        .i_hCnt    (r_hCnt),
        .i_vCnt    (r_vCnt),
        .i_blank   (w_blank),
        .o_rgb     (w_rgb)
    );

    always_ff @(posedge px_clk) begin
        if (rst) begin
            r_hCnt <= '0;
            r_vCnt <= '0;
        end else if (ce) begin
            if (w_hLast) begin
                r_hCnt <= '0;
                r_vCnt <= w_vLast ? '0 : r_vCnt + 10'd1;
            end else begin
                r_hCnt <= r_hCnt + 10'd1;
            end
        end
    end

    // The frame counter bumps one beat after the raster wraps so that the new
    // count appears alongside the (0,0) beat of the next frame.
    always_ff @(posedge px_clk) begin
        if (rst) begin
            RGBStr_o    <= packStream(~HS_POL, ~VS_POL, 1'b1, '0, '0, '0);
            frame_end_o <= 1'b0;
            frame_cnt_o <= 16'd0;
            r_wrapPend  <= 1'b0;
        end else if (ce) begin
            RGBStr_o    <= packStream(w_hSync, w_vSync, w_blank, r_hCnt, r_vCnt, w_rgb);
            frame_end_o <= w_frameEnd;
            r_wrapPend  <= w_hLast && w_vLast;
            if (r_wrapPend) begin
                frame_cnt_o <= frame_cnt_o + 16'd1;
            end
        end else begin
            frame_end_o <= 1'b0;
        end
    end

endmodule

// File: tb/tb_pxs_sync_gen.sv
// Randomised bench for pxs_sync_gen: four configurations share the stimulus
// and are compared each cycle against a beat-index reference model.
module tb_pxs_sync_gen;

    typedef struct {
        int hvis, hfp, hsw, hbp;
        int vvis, vfp, vsw, vbp;
        int pat;
        bit hp, vp;
    } cfg_t;

    logic        px_clk = 1'b0;
    logic        rst;
    logic        ce;
    logic [25:0] stream [4];
    logic        fe     [4];
    logic [15:0] fcnt   [4];

    cfg_t        cfg    [4];
    logic [25:0] expStr [4];
    logic        expFe  [4];
    logic [15:0] expCnt [4];
    int          beatIdx;
    int          checks = 0;
    int          errors = 0;

    initial forever #5 px_clk = ~px_clk;

    pxs_sync_gen dut0 (
        .px_clk(px_clk), .rst(rst), .ce(ce),
        .RGBStr_o(stream[0]), .frame_end_o(fe[0]), .frame_cnt_o(fcnt[0])
    );

    pxs_sync_gen #(
        .HVIS(64), .HFP(4), .HSW(8), .HBP(4), .VVIS(40), .VFP(2), .VSW(2), .VBP(3),
        .HS_POL(1'b1), .VS_POL(1'b0), .PATTERN(1)
    ) dut1 (
        .px_clk(px_clk), .rst(rst), .ce(ce),
        .RGBStr_o(stream[1]), .frame_end_o(fe[1]), .frame_cnt_o(fcnt[1])
    );

    pxs_sync_gen #(
        .HVIS(64), .HFP(4), .HSW(8), .HBP(4), .VVIS(40), .VFP(2), .VSW(2), .VBP(3),
        .HS_POL(1'b0), .VS_POL(1'b1), .PATTERN(2)
    ) dut2 (
        .px_clk(px_clk), .rst(rst), .ce(ce),
        .RGBStr_o(stream[2]), .frame_end_o(fe[2]), .frame_cnt_o(fcnt[2])
    );

    pxs_sync_gen #(
        .HVIS(64), .HFP(4), .HSW(8), .HBP(4), .VVIS(40), .VFP(2), .VSW(2), .VBP(3),
        .HS_POL(1'b0), .VS_POL(1'b0), .PATTERN(0)
    ) dut3 (
        .px_clk(px_clk), .rst(rst), .ce(ce),
        .RGBStr_o(stream[3]), .frame_end_o(fe[3]), .frame_cnt_o(fcnt[3])
    );

    // Expected stream word for the k-th beat since reset, from the raster rules.
    function automatic logic [25:0] beatOf(input cfg_t c, input int k);
        int htot = c.hvis + c.hfp + c.hsw + c.hbp;
        int vtot = c.vvis + c.vfp + c.vsw + c.vbp;
        int x = k % htot;
        int y = (k / htot) % vtot;
        bit blank = (x >= c.hvis) || (y >= c.vvis);
        bit hs = (x >= c.hvis + c.hfp && x < c.hvis + c.hfp + c.hsw) ? c.hp : !c.hp;
        bit vs = (y >= c.vvis + c.vfp && y < c.vvis + c.vfp + c.vsw) ? c.vp : !c.vp;
        logic [2:0] rgb = 3'b000;
        if (!blank) begin
            if (c.pat == 1) rgb = 3'(x / (c.hvis / 8));
            else if (c.pat == 2) rgb = ((((x / 32) + (y / 32)) % 2) == 1) ? 3'b111 : 3'b000;
        end
        return {hs, vs, blank, 10'(x), 10'(y), rgb};
    endfunction

    function automatic logic frameEndOf(input cfg_t c, input int k);
        int htot = c.hvis + c.hfp + c.hsw + c.hbp;
        int vtot = c.vvis + c.vfp + c.vsw + c.vbp;
        return ((k % htot) == c.hvis - 1) && (((k / htot) % vtot) == c.vvis - 1);
    endfunction

    function automatic logic [15:0] frameCntOf(input cfg_t c, input int k);
        int ftot = (c.hvis + c.hfp + c.hsw + c.hbp) * (c.vvis + c.vfp + c.vsw + c.vbp);
        return 16'(k / ftot);
    endfunction

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        if (observed !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: observed=%h expected=%h", tag, $time, observed, expected);
        end
    endtask

    task automatic checkCycle();
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("stream%0d", i), 32'(stream[i]), 32'(expStr[i]));
            checkOutput($sformatf("frame_end%0d", i), 32'(fe[i]), 32'(expFe[i]));
            checkOutput($sformatf("frame_cnt%0d", i), 32'(fcnt[i]), 32'(expCnt[i]));
        end
    endtask

    // Check the outputs of the previous edge, then drive the next edge's
    // inputs and advance the reference model to match.
    task automatic applyStimulus(input logic r, input logic c);
        @(negedge px_clk);
        checkCycle();
        rst = r;
        ce  = c;
        for (int i = 0; i < 4; i++) begin
            if (r) begin
                expStr[i] = {!cfg[i].hp, !cfg[i].vp, 1'b1, 23'd0};
                expFe[i]  = 1'b0;
                expCnt[i] = 16'd0;
            end else if (c) begin
                expStr[i] = beatOf(cfg[i], beatIdx);
                expFe[i]  = frameEndOf(cfg[i], beatIdx);
                expCnt[i] = frameCntOf(cfg[i], beatIdx);
            end else begin
                expFe[i]  = 1'b0;
            end
        end
        if (r) beatIdx = 0;
        else if (c) beatIdx++;
    endtask

    initial begin
        cfg[0] = '{hvis:640, hfp:16, hsw:96, hbp:48, vvis:480, vfp:10, vsw:2, vbp:33, pat:0, hp:1'b0, vp:1'b0};
        cfg[1] = '{hvis:64, hfp:4, hsw:8, hbp:4, vvis:40, vfp:2, vsw:2, vbp:3, pat:1, hp:1'b1, vp:1'b0};
        cfg[2] = '{hvis:64, hfp:4, hsw:8, hbp:4, vvis:40, vfp:2, vsw:2, vbp:3, pat:2, hp:1'b0, vp:1'b1};
        cfg[3] = '{hvis:64, hfp:4, hsw:8, hbp:4, vvis:40, vfp:2, vsw:2, vbp:3, pat:0, hp:1'b0, vp:1'b0};
        rst = 1'b1;
        ce  = 1'b0;
        beatIdx = 0;
        for (int i = 0; i < 4; i++) begin
            expStr[i] = {!cfg[i].hp, !cfg[i].vp, 1'b1, 23'd0};
            expFe[i]  = 1'b0;
            expCnt[i] = 16'd0;
        end

        $display("[TB] reset and idle");
        for (int n = 0; n < 4; n++) applyStimulus(1'b1, n[0]);
        for (int n = 0; n < 3; n++) applyStimulus(1'b0, 1'b0);

        $display("[TB] continuous ce over two small frames");
        for (int n = 0; n < 7800; n++) applyStimulus(1'b0, 1'b1);

        $display("[TB] random ce");
        for (int n = 0; n < 8000; n++) applyStimulus(1'b0, ($urandom % 2) != 0);

        $display("[TB] reset mid-frame with ce high");
        for (int n = 0; n < 2; n++) applyStimulus(1'b1, 1'b1);
        for (int n = 0; n < 3000; n++) applyStimulus(1'b0, 1'b1);

        $display("[TB] ce every other cycle");
        for (int n = 0; n < 8000; n++) applyStimulus(1'b0, n[0]);

        $display("[TB] random ce with occasional reset");
        for (int n = 0; n < 6000; n++) applyStimulus(($urandom % 1500) == 0, ($urandom % 4) != 0);

        @(negedge px_clk);
        checkCycle();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
